// File: rtl/serial_dec2.sv
// Serial decrementer: subtracts a 1-bit borrow from WIDTH bits, one 2-bit slice per clock,
// LSB slice first, with a start/busy/done handshake.
module serial_dec2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             bo
);
  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sh;
  logic             r_bor;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_bo;

  logic [1:0]       w_d;
  logic [1:0]       w_slice;
  logic             w_bnext;
  logic [WIDTH-1:0] w_sh_nxt;
  logic             w_last;

  // One slice of the borrow chain; the borrow dies as soon as a nonzero slice absorbs it.
  assign w_d      = r_sh[1:0];
  assign w_slice  = w_d - {1'b0, r_bor};
  assign w_bnext  = r_bor & (w_d == 2'b00);
  assign w_sh_nxt = (r_sh >> 2) | (WIDTH'(w_slice) << (WIDTH - 2));
  assign w_last   = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sh     <= '0;
      r_bor    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_bo     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sh    <= operand;
            r_bor   <= bi;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sh  <= w_sh_nxt;
          r_bor <= w_bnext;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_result <= w_sh_nxt;
            r_bo     <= w_bnext;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign bo     = r_bo;
endmodule

// File: tb/tb_serial_dec2.sv
// Self-checking bench for serial_dec2 (WIDTH=8): directed cases plus random operands
// against an arithmetic reference (operand - bi mod 2^WIDTH, underflow flag).
module tb_serial_dec2;
  localparam int WIDTH = 8;
  localparam int N     = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] operand;
  logic             bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             bo;

  int total = 0;
  int bad   = 0;

  serial_dec2 #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .operand (operand),
    .bi      (bi),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .bo      (bo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_res(input logic [WIDTH-1:0] op, input logic b);
    ref_res = WIDTH'((int'(op) - int'(b) + (1 << WIDTH)) % (1 << WIDTH));
  endfunction

  function automatic logic ref_bo(input logic [WIDTH-1:0] op, input logic b);
    ref_bo = (op == '0) && b;
  endfunction

  // Full operation: accept, measure accept-to-done latency, check outputs, check return to idle.
  task automatic run_op(input logic [WIDTH-1:0] op, input logic b, input string tag);
    int lat;
    operand = op; bi = b; start = 1'b1;
    step();
    start = 1'b0;
    operand = WIDTH'($urandom); bi = 1'($urandom);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(N + 1));
    chk({tag, "_res"}, 32'(result), 32'(ref_res(op, b)));
    chk({tag, "_bo"},  32'(bo), 32'(ref_bo(op, b)));
    step();
    chk({tag, "_donepulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone, prev, npulse;
    logic [WIDTH-1:0] rop;
    logic rb;

    rst = 1'b1; start = 1'b0; operand = '0; bi = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res",  32'(result), 32'd0);
    chk("rst_bo",   32'(bo), 32'd0);
    #10 rst = 1'b0;
    step();

    run_op(8'h00, 1'b1, "wrap");
    run_op(8'h10, 1'b1, "ripple");
    run_op(8'hA7, 1'b1, "a7");
    run_op(8'h5C, 1'b0, "nobor");
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_5c", 32'(result), 32'h5C);
    end

    // start pulses while busy must be ignored
    operand = 8'h01; bi = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int e = 1; e <= 12; e++) begin
      if (e == 2 || e == 4) begin
        start = 1'b1; operand = 8'h33;
      end
      step();
      start = 1'b0;
      if (done) ndone++;
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_res", 32'(result), 32'h00);
    chk("ign_bo",  32'(bo), 32'd0);

    // asynchronous reset mid-RUN
    run_op(8'h55, 1'b1, "pre_rst");
    operand = 8'h80; bi = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_res",  32'(result), 32'd0);
    chk("arst_bo",   32'(bo), 32'd0);
    #3 rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) ndone++;
    end
    chk("arst_nodone", 32'(ndone), 32'd0);
    run_op(8'h80, 1'b1, "after_rst");

    // start held high: back-to-back operations every N+2 cycles
    operand = 8'h03; bi = 1'b1; start = 1'b1;
    prev = -1; npulse = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done) begin
        chk("held_res", 32'(result), 32'h02);
        if (prev >= 0) chk("held_period", 32'(c - prev), 32'(N + 2));
        prev = c;
        npulse++;
      end
    end
    start = 1'b0;
    chk("held_npulse", 32'(npulse), 32'd3);
    for (int i = 0; i < 8; i++) step();

    for (int i = 0; i < 20; i++) begin
      rop = WIDTH'($urandom);
      if (i % 5 == 0) rop = '0;
      rb = 1'($urandom);
      run_op(rop, rb, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
